stream_covariance: RTL

STREAM_COVARIANCE -- requirements
Module: stream_covariance

---
 rtl/stream_covariance_if.sv | 33 +++
 rtl/stream_covariance.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/stream_covariance_if.sv
// Sample-stream and result bundle for stream_covariance.
// slave is the covariance engine's side, master is the producer/consumer side.
interface stream_covariance_if #(
  parameter int N_CH   = 8,
  parameter int N_SAMP = 8,
  parameter int N_BITS = 32
);
  localparam int LOG2_S = $clog2(N_SAMP);
  localparam int C_W    = N_BITS + 1;
  localparam int ACC_W  = 2 * C_W + LOG2_S;

  // Handshake: a beat transfers on a rising clk edge where in_valid and
  // in_ready are both high; in_valid may drop at any time and only stalls.
  logic                     start;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [N_BITS-1:0] in_data  [N_CH];
  logic signed [N_BITS-1:0] mean_out [N_CH];
  logic signed [ACC_W-1:0]  cov_out  [N_CH][N_CH];
  logic                     busy;
  logic                     done;
  logic                     result_valid;

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, mean_out, cov_out, busy, done, result_valid
  );

  modport master (
    output start, in_valid, in_data,
    input  in_ready, mean_out, cov_out, busy, done, result_valid
  );
endinterface

// File: rtl/stream_covariance.sv
// Frame-based per-channel mean and D*D^T covariance of centred sample vectors.
// Define STREAM_COVARIANCE_NORMALISE_EN to output acc >>> log2(N_SAMP) instead of raw acc.
module stream_covariance #(
  parameter int N_CH   = 8,
  parameter int N_SAMP = 8,
  parameter int N_BITS = 32
) (
  input  logic                clk,
  input  logic                rst,
  stream_covariance_if.slave  bus,
  output logic [2:0]          dbg_state_o
);
  localparam int LOG2_S = $clog2(N_SAMP);
  localparam int C_W    = N_BITS + 1;
  localparam int ACC_W  = 2 * C_W + LOG2_S;
  localparam int S_W    = N_BITS + LOG2_S;
  localparam int P_W    = 2 * C_W;

  typedef enum logic [2:0] {IDLE, LOAD, MEAN, ACC, DONE} state_t;

  state_t state_q, state_d;

  logic [LOG2_S-1:0]        idx_q, idx_d;
  logic signed [N_BITS-1:0] smp_q      [N_SAMP][N_CH];
  logic signed [S_W-1:0]    sum_q      [N_CH];
  logic signed [S_W-1:0]    sum_d      [N_CH];
  logic signed [N_BITS-1:0] mean_q     [N_CH];
  logic signed [N_BITS-1:0] mean_d     [N_CH];
  logic signed [N_BITS-1:0] mean_out_q [N_CH];
  logic signed [N_BITS-1:0] mean_out_d [N_CH];
  logic signed [ACC_W-1:0]  acc_q      [N_CH][N_CH];
  logic signed [ACC_W-1:0]  acc_d      [N_CH][N_CH];
  logic signed [ACC_W-1:0]  cov_q      [N_CH][N_CH];
  logic signed [ACC_W-1:0]  cov_d      [N_CH][N_CH];
  logic signed [C_W-1:0]    cen        [N_CH];
  logic signed [P_W-1:0]    prod       [N_CH][N_CH];
  logic                     rv_q, rv_d;
  logic                     accept;
  logic                     last_idx;

  assign accept   = bus.in_valid && (state_q == LOAD);
  assign last_idx = (idx_q == LOG2_S'(N_SAMP - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = LOAD;
      LOAD:    if (accept && last_idx) state_d = MEAN;
      MEAN:    state_d = ACC;
      ACC:     if (last_idx) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    idx_d      = idx_q;
    sum_d      = sum_q;
    mean_d     = mean_q;
    mean_out_d = mean_out_q;
    acc_d      = acc_q;
    cov_d      = cov_q;
    rv_d       = rv_q;

    // Centred sample and outer product for the buffer slot idx addresses.
    for (int i = 0; i < N_CH; i++) begin
      cen[i] = C_W'(smp_q[idx_q][i]) - C_W'(mean_q[i]);
    end
    for (int i = 0; i < N_CH; i++) begin
      for (int j = 0; j < N_CH; j++) begin
        prod[i][j] = P_W'(cen[i]) * P_W'(cen[j]);
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          idx_d = '0;
          rv_d  = 1'b0;
          for (int i = 0; i < N_CH; i++) begin
            sum_d[i] = '0;
            for (int j = 0; j < N_CH; j++) acc_d[i][j] = '0;
          end
        end
      end
      LOAD: begin
        if (accept) begin
          idx_d = idx_q + 1'b1;
          for (int i = 0; i < N_CH; i++) sum_d[i] = sum_q[i] + S_W'(bus.in_data[i]);
        end
      end
      MEAN: begin
        idx_d = '0;
        for (int i = 0; i < N_CH; i++) mean_d[i] = N_BITS'(sum_q[i] >>> LOG2_S);
      end
      ACC: begin
        idx_d = idx_q + 1'b1;
        for (int i = 0; i < N_CH; i++) begin
          for (int j = 0; j < N_CH; j++) acc_d[i][j] = acc_q[i][j] + ACC_W'(prod[i][j]);
        end
        // Results are published from the final accumulator value on the edge into DONE.
        if (last_idx) begin
          rv_d       = 1'b1;
          mean_out_d = mean_q;
          for (int i = 0; i < N_CH; i++) begin
            for (int j = 0; j < N_CH; j++) begin
`ifdef STREAM_COVARIANCE_NORMALISE_EN
              cov_d[i][j] = acc_d[i][j] >>> LOG2_S;
`else
              cov_d[i][j] = acc_d[i][j];
`endif
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rv_q    <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        sum_q[i]      <= '0;
        mean_q[i]     <= '0;
        mean_out_q[i] <= '0;
        for (int j = 0; j < N_CH; j++) begin
          acc_q[i][j] <= '0;
          cov_q[i][j] <= '0;
        end
      end
      for (int k = 0; k < N_SAMP; k++) begin
        for (int i = 0; i < N_CH; i++) smp_q[k][i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rv_q       <= rv_d;
      sum_q      <= sum_d;
      mean_q     <= mean_d;
      mean_out_q <= mean_out_d;
      acc_q      <= acc_d;
      cov_q      <= cov_d;
      if (accept) smp_q[idx_q] <= bus.in_data;
    end
  end

  assign bus.in_ready     = (state_q == LOAD);
  assign bus.busy         = (state_q != IDLE);
  assign bus.done         = (state_q == DONE);
  assign bus.result_valid = rv_q;
  assign bus.mean_out     = mean_out_q;
  assign bus.cov_out      = cov_q;
  assign dbg_state_o      = state_q;
endmodule
